if_id_stage: RTL

//  IF->ID pipeline boundary. Captures the fetch PC, aligns it with the synchronous instruction-ROM

---
 rtl/if_id_stage_pkg.sv | 12 +
 rtl/if_id_hold_buf.sv | 24 ++
 rtl/if_id_stage.sv | 96 +++++++++
 3 files changed

// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the IF->ID pipeline boundary: instruction width, bubble word and state encoding.
package if_id_stage_pkg;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam logic [INSTR_WIDTH-1:0] IF_ID_NOP = 32'h0000_0000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } if_id_state_e;

endpackage

// File: rtl/if_id_hold_buf.sv
// Holding register for the ROM word across stalls, plus the mux that selects it over the live ROM output.
module if_id_hold_buf #(
  parameter int unsigned          W       = 32,
  parameter logic [W-1:0]         RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         capture,
  input  logic         sel,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] hold_q;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)          hold_q <= RST_VAL;
    else if (capture) hold_q <= d;
  end

  assign q = sel ? hold_q : d;

endmodule

// File: rtl/if_id_stage.sv
// IF->ID pipeline register: aligns fetch PC with synchronous ROM data, holds on stall, bubbles on flush.
// Define IF_ID_PERF_EN to add the stall_cnt/flush_cnt performance counters.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int unsigned        DATA_W   = INSTR_WIDTH,
  parameter logic [DATA_W-1:0]  RESET_PC = 32'h0000_0000,
  parameter logic [DATA_W-1:0]  NOP_WORD = IF_ID_NOP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] if_pc,
  input  logic [DATA_W-1:0] if_instr,
  output logic [DATA_W-1:0] id_instr,
  output logic [DATA_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_pc4,
  output logic              id_valid
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  if_id_state_e      state_q, state_d;
  logic [DATA_W-1:0] pc_q;
  logic              valid_q;
  logic              capture;
  logic              sel_hold;
  logic [DATA_W-1:0] buf_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = ST_RUN;
    if (flush)      state_d = ST_RUN;
    else if (stall) state_d = ST_HOLD;
  end

  // Capture only on entry to HOLD; later stall cycles must keep the first word.
  always_comb begin
    capture  = 1'b0;
    sel_hold = 1'b0;
    if (state_q == ST_RUN && stall && !flush) capture = 1'b1;
    if (state_q == ST_HOLD)                   sel_hold = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else if (flush) begin
      pc_q    <= if_pc;
      valid_q <= 1'b0;
    end else if (!stall) begin
      pc_q    <= if_pc;
      valid_q <= 1'b1;
    end
  end

  if_id_hold_buf #(
    .W       (DATA_W),
    .RST_VAL (NOP_WORD)
  ) u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .capture (capture),
    .sel     (sel_hold),
    .d       (if_instr),
    .q       (buf_q)
  );

  assign id_instr = valid_q ? buf_q : NOP_WORD;
  assign id_pc    = pc_q;
  assign id_pc4   = pc_q + DATA_W'(4);
  assign id_valid = valid_q;

`ifdef IF_ID_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (flush)      flush_cnt <= flush_cnt + 32'd1;
      else if (stall) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
